// File: rtl/service_lap_stopwatch_pkg.sv
// Shared definitions for the lap stopwatch service.
// State encoding is also decoded by the top-level mode mux.
package service_lap_stopwatch_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  localparam int BCD_W = 4;

endpackage

// File: rtl/service_lap_stopwatch_if.sv
// Push-button / display bundle between the mode mux and the stopwatch.
// master = mux side, slave = stopwatch service.
interface service_lap_stopwatch_if #(
  parameter int DIGITS = 4,
  parameter int N_LAPS = 4
) ();
  localparam int BCD_W = service_lap_stopwatch_pkg::BCD_W;
  localparam int LAP_W = $clog2(N_LAPS + 1);

  logic                    enable;
  logic                    push_m;
  logic                    push_lap;
  logic                    push_view;
  logic [BCD_W*DIGITS-1:0] segments;
  logic                    led;
  logic                    running;
  logic                    finish;
  logic                    overflow;
  logic [LAP_W-1:0]        lap_count;
  logic [LAP_W-1:0]        view_idx;

  modport master (
    output enable, push_m, push_lap, push_view,
    input  segments, led, running, finish,
    input  overflow, lap_count, view_idx
  );

  modport slave (
    input  enable, push_m, push_lap, push_view,
    output segments, led, running, finish,
    output overflow, lap_count, view_idx
  );
endinterface

// File: rtl/service_lap_stopwatch_bcd_digit.sv
// One 0..9 BCD digit of the elapsed-time counter.
// sat_i blocks counting so the chain holds at all-9s.
module service_lap_stopwatch_bcd_digit
  import service_lap_stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             sat_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             carry_o
);

  logic [BCD_W-1:0] digit_q, digit_d;
  logic             step;

  assign step    = inc_i && !sat_i;
  assign carry_o = step && (digit_q == BCD_W'(9));
  assign digit_o = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = '0;
    end else if (step) begin
      digit_d = carry_o ? '0 : digit_q + BCD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/service_lap_stopwatch.sv
// Lap stopwatch service: BCD run timer, lap buffer with recall,
// saturation flag and a finish pulse back to the mode mux.
module service_lap_stopwatch
  import service_lap_stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int DIGITS   = 4,
  parameter int N_LAPS   = 4
) (
  input logic                    clk,
  input logic                    reset,
  service_lap_stopwatch_if.slave sw
);

  localparam int LAP_W = $clog2(N_LAPS + 1);
  localparam int SEG_W = BCD_W * DIGITS;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SEG_W-1:0] laps_q [N_LAPS];
  logic [LAP_W-1:0] lap_count_q, lap_count_d;
  logic [LAP_W-1:0] view_q, view_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             led_q, running_q;
  logic             finish_q, finish_d;
  logic             ovf_q, ovf_d;

  logic             clr, pre_clr, count_en;
  logic             lap_wr, strobe, all9;
  logic [SEG_W-1:0] cnt, lap_sel;
  logic [DIGITS:0]  carry;
  logic [DIGITS-1:0] nine;

  always_comb begin
    state_d  = state_q;
    view_d   = view_q;
    clr      = 1'b0;
    pre_clr  = 1'b0;
    count_en = 1'b0;
    lap_wr   = 1'b0;
    finish_d = 1'b0;
    if (!sw.enable) begin
      state_d = S_OFF;
      if (state_q != S_OFF) begin
        finish_d = 1'b1;
        clr      = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_OFF: begin
          state_d = S_READY;
          clr     = 1'b1;
        end
        S_READY: begin
          if (sw.push_m) begin
            state_d = S_RUN;
            pre_clr = 1'b1;
          end
        end
        S_RUN: begin
          if (sw.push_m) begin
            state_d = S_PAUSE;
          end else begin
            count_en = 1'b1;
            lap_wr   = sw.push_lap &&
                       (lap_count_q != LAP_W'(N_LAPS));
          end
        end
        S_PAUSE: begin
          if (sw.push_m) begin
            state_d = S_RUN;
            view_d  = '0;
          end else if (sw.push_lap) begin
            state_d = S_READY;
            clr     = 1'b1;
          end else if (sw.push_view) begin
            view_d = (view_q == lap_count_q) ?
                     '0 : view_q + LAP_W'(1);
          end
        end
        default: state_d = S_OFF;
      endcase
    end
    if (clr) view_d = '0;
  end

  // Strobe fires on the prescaler wrap while the service stays in RUN.
  assign strobe = count_en && (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    pre_d = pre_q;
    if (clr || pre_clr) begin
      pre_d = '0;
    end else if (count_en) begin
      pre_d = strobe ? '0 : pre_q + PRE_W'(1);
    end
  end

  assign carry[0] = strobe;
  assign all9     = &nine;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    service_lap_stopwatch_bcd_digit u_digit (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clr),
      .inc_i   (carry[i]),
      .sat_i   (all9),
      .digit_o (cnt[i*BCD_W +: BCD_W]),
      .carry_o (carry[i+1])
    );
    assign nine[i] = (cnt[i*BCD_W +: BCD_W] == BCD_W'(9));
  end

  always_comb begin
    lap_sel = '0;
    for (int k = 0; k < N_LAPS; k++) begin
      if (view_q == LAP_W'(k + 1)) lap_sel = laps_q[k];
    end
  end

  always_comb begin
    lap_count_d = lap_count_q;
    if (clr) lap_count_d = '0;
    else if (lap_wr) lap_count_d = lap_count_q + LAP_W'(1);
  end

  assign ovf_d = !clr && (ovf_q || (strobe && all9));
  assign seg_d = (state_d == S_OFF || clr) ? '0 :
                 (view_q == '0) ? cnt : lap_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OFF;
      pre_q       <= '0;
      lap_count_q <= '0;
      view_q      <= '0;
      seg_q       <= '0;
      led_q       <= 1'b0;
      running_q   <= 1'b0;
      finish_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      lap_count_q <= lap_count_d;
      view_q      <= view_d;
      seg_q       <= seg_d;
      led_q       <= (state_d != S_OFF);
      running_q   <= (state_d == S_RUN);
      finish_q    <= finish_d;
      ovf_q       <= ovf_d;
    end
  end

  // Lap slots capture the pre-increment count of the push cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_LAPS; k++) begin
      if (reset || clr) begin
        laps_q[k] <= '0;
      end else if (lap_wr && lap_count_q == LAP_W'(k)) begin
        laps_q[k] <= cnt;
      end
    end
  end

  assign sw.segments  = seg_q;
  assign sw.led       = led_q;
  assign sw.running   = running_q;
  assign sw.finish    = finish_q;
  assign sw.overflow  = ovf_q;
  assign sw.lap_count = lap_count_q;
  assign sw.view_idx  = view_q;

endmodule
